// File: rtl/mem_arbiter.sv
// Purpose: two-port (fetch / load-store) arbiter in front of one shared single-port word RAM.
// Latency: grant is combinational in the request cycle; the response (rvalid/rdata/err) is registered and arrives one cycle later.
// Backpressure: a requester holds req and its fields until gnt; on a conflict the side not served most recently wins.
//
// Ports:
//   clk, rst_n                      - single rising-edge clock, async active-low reset
//   if_req/if_addr -> if_gnt        - instruction fetch read request (byte address)
//   if_rvalid/if_rdata/if_err       - fetch response, one cycle after if_gnt
//   d_req/d_we/d_addr/d_wdata       - load/store request (byte address)
//   d_gnt, d_rvalid/d_rdata/d_err   - load/store grant and response
//   ram_we/ram_addr/ram_wdata       - shared RAM command (combinational read, write on clock edge)
//   ram_rdata                       - shared RAM read data for the address driven this cycle
module mem_arbiter #(
    parameter int DEPTH = 101
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    // Which requester was granted most recently; the other one wins a conflict.
    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    // Misaligned or beyond the last word of the RAM.
    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= DEPTH_W);
    endfunction

    owner_e      last_owner_q, last_owner_d;

    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic        if_err_q,    if_err_d;

    logic        d_rvalid_q,  d_rvalid_d;
    logic [31:0] d_rdata_q,   d_rdata_d;
    logic        d_err_q,     d_err_d;

    logic        if_bad;
    logic        d_bad;
    logic        grant_if;
    logic        grant_d;

    assign if_bad = addr_bad(if_addr);
    assign d_bad  = addr_bad(d_addr);

    // Arbitration. Grants are gated with rst_n so that an access whose grant
    // cycle overlaps reset is dropped entirely: no RAM write and no response.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (rst_n) begin
            if (d_req && (!if_req || (last_owner_q == OWNER_IF))) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    assign if_gnt = grant_if;
    assign d_gnt  = grant_d;

    // RAM command. The address is forwarded only for a granted access, and an
    // erroring store never reaches the write enable.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = 32'h0;
        ram_wdata = 32'h0;
        if (grant_d) begin
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
            ram_we    = d_we && !d_bad;
        end else if (grant_if) begin
            ram_addr  = if_addr;
            ram_wdata = d_wdata;
        end
    end

    // Ownership follows every grant, including one that returns an error.
    always_comb begin
        last_owner_d = last_owner_q;
        if (grant_d) begin
            last_owner_d = OWNER_D;
        end else if (grant_if) begin
            last_owner_d = OWNER_IF;
        end
    end

    // Response next-state. Read data is captured from the RAM at the grant
    // edge; stores and errors return zero data.
    always_comb begin
        if_rvalid_d = grant_if;
        if_err_d    = grant_if && if_bad;
        if_rdata_d  = 32'h0;
        if (grant_if && !if_bad) begin
            if_rdata_d = ram_rdata;
        end

        d_rvalid_d = grant_d;
        d_err_d    = grant_d && d_bad;
        d_rdata_d  = 32'h0;
        if (grant_d && !d_we && !d_bad) begin
            d_rdata_d = ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OWNER_IF;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= 32'h0;
            if_err_q     <= 1'b0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= 32'h0;
            d_err_q      <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            d_rvalid_q   <= d_rvalid_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

    // The single RAM port can serve only one requester per cycle.
    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(if_gnt && d_gnt));

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter with a behavioural shared RAM.
// Latency: inputs driven on the falling edge, grants checked 1 ns later, responses checked at the next falling edge.
// Backpressure: requests are held high until the granted cycle has been checked.
module tb_mem_arbiter;

    localparam int DEPTH = 101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Shared RAM: combinational read, write on the rising edge. The preload
    // port is used only while the arbiter is held in reset.
    logic [31:0] mem [0:DEPTH-1];
    logic        pl_we;
    logic [6:0]  pl_idx;
    logic [31:0] pl_dat;
    logic [31:0] widx;

    assign widx      = {2'b00, ram_addr[31:2]};
    assign ram_rdata = (widx < 32'(DEPTH)) ? mem[widx[6:0]] : 32'h0;

    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_idx] <= pl_dat;
        end else if (ram_we && (widx < 32'(DEPTH))) begin
            mem[widx[6:0]] <= ram_wdata;
        end
    end

    task automatic preload(input logic [6:0] idx, input logic [31:0] dat);
        pl_we  = 1'b1;
        pl_idx = idx;
        pl_dat = dat;
        @(posedge clk);
        #1;
        pl_we  = 1'b0;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
    endtask

    // Both requesters active while reset is held: nothing may move.
    task automatic test_reset;
        @(negedge clk);
        drive(1'b1, 32'hC, 1'b1, 1'b0, 32'h14, 32'h0);
        #1;
        total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL rst_if_gnt: got %b want 0", if_gnt); end
        total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL rst_d_gnt: got %b want 0", d_gnt); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
        total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL rst_if_rvalid: got %b want 0", if_rvalid); end
        total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL rst_d_rvalid: got %b want 0", d_rvalid); end
        total++; if (if_err !== 1'b0 || d_err !== 1'b0) begin bad++; $display("FAIL rst_err: got if=%b d=%b want 0 0", if_err, d_err); end
        total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL rst_if_rdata: got %h want 0", if_rdata); end
        total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL rst_d_rdata: got %h want 0", d_rdata); end
    endtask

    // Continuous requests from both sides starting at reset release:
    // D,F,D,F,D,F with one response per grant a cycle later.
    task automatic test_alternate;
        logic prev_d;
        logic exp_d;
        prev_d = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin
                total++; if (d_rvalid !== prev_d) begin bad++; $display("FAIL alt_d_rvalid[%0d]: got %b want %b", k, d_rvalid, prev_d); end
                total++; if (if_rvalid !== !prev_d) begin bad++; $display("FAIL alt_if_rvalid[%0d]: got %b want %b", k, if_rvalid, !prev_d); end
                if (prev_d) begin
                    total++; if (d_rdata !== 32'h55555555) begin bad++; $display("FAIL alt_d_rdata[%0d]: got %h want 55555555", k, d_rdata); end
                end else begin
                    total++; if (if_rdata !== 32'h33333333) begin bad++; $display("FAIL alt_if_rdata[%0d]: got %h want 33333333", k, if_rdata); end
                end
            end
            if (k == 6) begin
                drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            end else begin
                #1;
                exp_d = (k % 2 == 0);
                total++; if (d_gnt !== exp_d) begin bad++; $display("FAIL alt_d_gnt[%0d]: got %b want %b", k, d_gnt, exp_d); end
                total++; if (if_gnt !== !exp_d) begin bad++; $display("FAIL alt_if_gnt[%0d]: got %b want %b", k, if_gnt, !exp_d); end
                prev_d = exp_d;
                @(negedge clk);
            end
        end
    endtask

    // Fetch-only read of 0x8 (word 2 = DEADBEEF).
    task automatic test_fetch_read;
        @(negedge clk);
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        total++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin bad++; $display("FAIL fr_gnt: got if=%b d=%b want 1 0", if_gnt, d_gnt); end
        total++; if (ram_addr !== 32'h8 || ram_we !== 1'b0) begin bad++; $display("FAIL fr_ram: got addr=%h we=%b want 8 0", ram_addr, ram_we); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        total++; if (if_rvalid !== 1'b1 || if_err !== 1'b0) begin bad++; $display("FAIL fr_rvalid: got v=%b e=%b want 1 0", if_rvalid, if_err); end
        total++; if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fr_rdata: got %h want deadbeef", if_rdata); end
        total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL fr_d_rvalid: got %b want 0", d_rvalid); end
        @(negedge clk);
        total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL fr_single: got %b want 0", if_rvalid); end
    endtask

    // Store then load of the same word on consecutive cycles.
    task automatic test_back_to_back;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h12345678);
        #1;
        total++; if (d_gnt !== 1'b1 || ram_we !== 1'b1) begin bad++; $display("FAIL bb_wr_gnt: got gnt=%b we=%b want 1 1", d_gnt, ram_we); end
        total++; if (ram_addr !== 32'h10 || ram_wdata !== 32'h12345678) begin bad++; $display("FAIL bb_wr_ram: got addr=%h wdata=%h want 10 12345678", ram_addr, ram_wdata); end
        @(negedge clk);
        total++; if (d_rvalid !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h0) begin bad++; $display("FAIL bb_wr_rsp: got v=%b e=%b d=%h want 1 0 0", d_rvalid, d_err, d_rdata); end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        total++; if (d_gnt !== 1'b1 || ram_we !== 1'b0) begin bad++; $display("FAIL bb_rd_gnt: got gnt=%b we=%b want 1 0", d_gnt, ram_we); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678) begin bad++; $display("FAIL bb_rd_rsp: got v=%b d=%h want 1 12345678", d_rvalid, d_rdata); end
    endtask

    // Misaligned and out-of-range accesses, plus the last valid word.
    task automatic test_errors;
        @(negedge clk);
        drive(1'b1, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL er_if_gnt: got %b want 1", if_gnt); end
        @(negedge clk);
        total++; if (if_rvalid !== 1'b1 || if_err !== 1'b1 || if_rdata !== 32'h0) begin bad++; $display("FAIL er_if_rsp: got v=%b e=%b d=%h want 1 1 0", if_rvalid, if_err, if_rdata); end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h6, 32'h0);
        #1;
        total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL er_rd6_gnt: got %b want 1", d_gnt); end
        @(negedge clk);
        total++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin bad++; $display("FAIL er_rd6_rsp: got v=%b e=%b d=%h want 1 1 0", d_rvalid, d_err, d_rdata); end
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'(4 * DEPTH), 32'hBAD0BAD0);
        #1;
        total++; if (d_gnt !== 1'b1 || ram_we !== 1'b0) begin bad++; $display("FAIL er_oor_wr: got gnt=%b we=%b want 1 0", d_gnt, ram_we); end
        @(negedge clk);
        total++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin bad++; $display("FAIL er_oor_rsp: got v=%b e=%b d=%h want 1 1 0", d_rvalid, d_err, d_rdata); end
        total++; if (mem[DEPTH-1] !== 32'hA0A0A0A0) begin bad++; $display("FAIL er_oor_mem: got %h want a0a0a0a0", mem[DEPTH-1]); end
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h11, 32'hCAFECAFE);
        #1;
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL er_mis_wr: got we=%b want 0", ram_we); end
        @(negedge clk);
        total++; if (d_err !== 1'b1) begin bad++; $display("FAIL er_mis_rsp: got e=%b want 1", d_err); end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        total++; if (d_rdata !== 32'h12345678 || d_err !== 1'b0) begin bad++; $display("FAIL er_mis_keep: got d=%h e=%b want 12345678 0", d_rdata, d_err); end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'(4 * (DEPTH - 1)), 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        total++; if (d_rdata !== 32'hA0A0A0A0 || d_err !== 1'b0) begin bad++; $display("FAIL er_last_word: got d=%h e=%b want a0a0a0a0 0", d_rdata, d_err); end
    endtask

    // Reset asserted in the middle of a store grant; last grant before this
    // was data, so a correct reset of the ownership lets data win again.
    task automatic test_reset_mid;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h24, 32'hFFFF0000);
        #1;
        total++; if (d_gnt !== 1'b1 || ram_we !== 1'b1) begin bad++; $display("FAIL rm_pre: got gnt=%b we=%b want 1 1", d_gnt, ram_we); end
        rst_n = 1'b0;
        #1;
        total++; if (d_gnt !== 1'b0 || if_gnt !== 1'b0 || ram_we !== 1'b0) begin bad++; $display("FAIL rm_gate: got d=%b if=%b we=%b want 0 0 0", d_gnt, if_gnt, ram_we); end
        @(negedge clk);
        total++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin bad++; $display("FAIL rm_rvalid: got d=%b if=%b want 0 0", d_rvalid, if_rvalid); end
        total++; if (d_rdata !== 32'h0 || d_err !== 1'b0) begin bad++; $display("FAIL rm_dout: got d=%h e=%b want 0 0", d_rdata, d_err); end
        total++; if (mem[9] !== 32'h99999999) begin bad++; $display("FAIL rm_mem: got %h want 99999999", mem[9]); end
        drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h24, 32'h0);
        rst_n = 1'b1;
        #1;
        total++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin bad++; $display("FAIL rm_first: got d=%b if=%b want 1 0", d_gnt, if_gnt); end
        @(negedge clk);
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h99999999) begin bad++; $display("FAIL rm_rd: got v=%b d=%h want 1 99999999", d_rvalid, d_rdata); end
        #1;
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rm_if_gnt: got %b want 1", if_gnt); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rm_if_rd: got v=%b d=%h want 1 deadbeef", if_rvalid, if_rdata); end
    endtask

    initial begin
        rst_n = 1'b0;
        pl_we = 1'b0;
        pl_idx = 7'd0;
        pl_dat = 32'h0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        preload(7'd2,   32'hDEADBEEF);
        preload(7'd3,   32'h33333333);
        preload(7'd4,   32'h44444444);
        preload(7'd5,   32'h55555555);
        preload(7'd9,   32'h99999999);
        preload(7'd100, 32'hA0A0A0A0);
        test_reset;
        test_alternate;
        test_fetch_read;
        test_back_to_back;
        test_errors;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
